// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains it through a 3-entry
// buffer and presents the words as a framed valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle
);

    // Stream handshake: a word moves when m_valid and m_ready are both high on
    // a rising edge; once raised, m_valid/m_data/m_last hold until that edge.

    logic [DATA_WIDTH-1:0] buffer [0:2];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  len_in;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [2:0]            fill;
    logic                  handshake;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for every read in flight so the buffer can never overflow,
    // which keeps m_ready out of the read-issue path.
    assign fill       = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = rst_n & enable & ~fifo_empty & (fill < 3'd3);

    assign m_valid   = (occ != 2'd0);
    assign m_data    = buffer[head];
    assign handshake = m_valid & m_ready;
    assign idle      = (occ == 2'd0) & ~inflight;

    // A packet length is latched on its first beat so later pkt_len changes
    // only affect the following packet.
    assign len_in  = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    assign eff_len = (beat_cnt == '0) ? len_in : len_q;
    assign m_last  = m_valid & (beat_cnt == eff_len - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buffer[i] <= '0;
            end
            head      <= 2'd0;
            tail      <= 2'd0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            beat_cnt  <= '0;
            len_q     <= '0;
            words_out <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ + {1'b0, inflight} - {1'b0, handshake};
            if (inflight) begin
                buffer[tail] <= fifo_data;
                tail         <= next_ptr(tail);
            end
            if (handshake) begin
                head      <= next_ptr(head);
                words_out <= words_out + CNT_WIDTH'(1);
                if (beat_cnt == '0) begin
                    len_q <= len_in;
                end
                if (m_last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, directed stimulus, and an
// expected-word queue popped by a monitor on every stream handshake.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic [LW-1:0] pkt_len;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] words_out;
    logic          idle;

    int n_vec = 0;
    int n_err = 0;
    int rd_count = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    logic          hold_pending = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .pkt_len(pkt_len), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .words_out(words_out), .idle(idle)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural FIFO with registered read data.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
        exp_q.push_back({last, d});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick(1);
        while (!(idle && fifo_empty) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) rd_count++;
            if (fifo_empty) chk("rd_while_empty", 32'(fifo_rd_en), 32'd0);
            if (hold_pending) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(held_data));
                chk("hold_last", 32'(m_last), 32'(held_last));
            end
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
            held_last    = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'({m_last, m_data}), 32'hFFFF_FFFF);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", 32'(m_data), 32'(e[DW-1:0]));
                    chk("word_last", 32'(m_last), 32'(e[DW]));
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        int r0;
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        pkt_len = 8'd1;
        push_word(8'hA5, 1'b1);

        // reset held 3 cycles with the FIFO non-empty
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", 32'(m_data), 32'd0);
            chk("rst_words_out", 32'(words_out), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
        end

        // single word: read at T, valid at T+2, counted at T+3
        rst_n = 1'b1;
        #1;
        chk("single_rd_T", 32'(fifo_rd_en), 32'd1);
        tick(1);
        chk("single_rd_T1", 32'(fifo_rd_en), 32'd0);
        chk("single_valid_T1", 32'(m_valid), 32'd0);
        tick(1);
        chk("single_valid_T2", 32'(m_valid), 32'd1);
        chk("single_data_T2", 32'(m_data), 32'hA5);
        chk("single_last_T2", 32'(m_last), 32'd1);
        tick(1);
        chk("single_words_T3", 32'(words_out), 32'd1);
        chk("single_idle_T3", 32'(idle), 32'd1);

        // streaming: 8 words, packets of 4, one beat per cycle
        pkt_len = 8'd4;
        for (int i = 1; i <= 8; i++) push_word(8'(i), (i % 4) == 0);
        tick(9);
        chk("stream_words_T9", 32'(words_out), 32'd8);
        tick(1);
        chk("stream_words_T10", 32'(words_out), 32'd9);
        chk("stream_idle", 32'(idle), 32'd1);

        // backpressure: 10 words, consumer stalled 20 cycles
        m_ready = 1'b0;
        r0 = rd_count;
        for (int i = 1; i <= 10; i++) push_word(8'(i), (i % 4) == 0);
        tick(20);
        chk("bp_reads", 32'(rd_count - r0), 32'd3);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        wait_idle(60);
        chk("bp_words", 32'(words_out), 32'd19);

        // enable drop after 2 reads; packet resumes at beat 2 of 4
        r0 = rd_count;
        for (int i = 0; i < 6; i++) push_word(8'h11 + 8'(i), (i == 1) || (i == 5));
        tick(2);
        enable = 1'b0;
        tick(8);
        chk("en_reads", 32'(rd_count - r0), 32'd2);
        chk("en_words", 32'(words_out), 32'd21);
        chk("en_idle", 32'(idle), 32'd1);
        chk("en_fifo_left", 32'(fifo_empty), 32'd0);
        enable = 1'b1;
        wait_idle(40);
        chk("en_words_after", 32'(words_out), 32'd25);

        // pkt_len 3 -> 5 mid-packet: first packet stays 3, next is 5
        pkt_len = 8'd3;
        for (int i = 0; i < 8; i++) push_word(8'h21 + 8'(i), (i == 2) || (i == 7));
        tick(4);
        pkt_len = 8'd5;
        wait_idle(40);
        chk("len_words", 32'(words_out), 32'd33);

        // pkt_len 0 behaves as 1: every beat is last
        pkt_len = 8'd0;
        for (int i = 0; i < 3; i++) push_word(8'h31 + 8'(i), 1'b1);
        wait_idle(40);
        chk("len0_words", 32'(words_out), 32'd36);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
